uart_batch_receiver: RTL and testbench

- Receive-side counterpart to the batch transmit path.
- Oversamples the serial rx line at 16x, deserialises 8N1 frames, and packs BATCH_SIZE consecutive bytes into one wide word.
- Presents each completed batch with a single-cycle valid pulse, so a host sending a batch with the batch transmitter gets the identical word back.
- Self-contained: internal baud tick generator, input synchroniser, frame-error and inter-byte timeout detection.

---
 rtl/uart_batch_receiver.sv | 151 +++++++++++++++
 tb/tb_uart_batch_receiver.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/uart_batch_receiver.sv
// rtl/uart_batch_receiver.sv - 16x oversampled 8N1 receiver that packs BATCH_SIZE bytes into one word
// First byte of a batch lands in the most significant slot.
module uart_batch_receiver #(
  parameter int DBITS         = 8,
  parameter int SB_TICK       = 16,
  parameter int BR_LIMIT      = 673,
  parameter int BR_BITS       = 10,
  parameter int BATCH_SIZE    = 4,
  parameter int TIMEOUT_TICKS = 320
) (
  input  logic                                 clk_100MHz,
  input  logic                                 reset,
  input  logic                                 rx,
  output logic [DBITS-1:0]                     byte_out,
  output logic                                 byte_valid,
  output logic [DBITS*BATCH_SIZE-1:0]          batch_out,
  output logic                                 batch_valid,
  output logic [$clog2(BATCH_SIZE+1)-1:0]      batch_count,
  output logic                                 frame_error,
  output logic                                 timeout,
  output logic                                 busy
);

  localparam int CW = $clog2(BATCH_SIZE+1);
  localparam int NW = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS+1);
  localparam int SW = DBITS*(BATCH_SIZE-1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                      state;
  logic                        rx_q1, rx_s;
  logic [BR_BITS-1:0]          br_cnt;
  logic                        tick;
  logic [3:0]                  s;
  logic [NW-1:0]               n;
  logic [DBITS-1:0]            shreg;
  logic [SW-1:0]               stage;
  logic [TW-1:0]               to_cnt;

  assign tick = (br_cnt == BR_BITS'(BR_LIMIT-1));
  assign busy = (state != IDLE);

  always_ff @(posedge clk_100MHz) begin
    if (!reset) begin
      state       <= IDLE;
      rx_q1       <= 1'b1;
      rx_s        <= 1'b1;
      br_cnt      <= '0;
      s           <= '0;
      n           <= '0;
      shreg       <= '0;
      stage       <= '0;
      to_cnt      <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
      batch_out   <= '0;
      batch_valid <= 1'b0;
      batch_count <= '0;
      frame_error <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      rx_q1       <= rx;
      rx_s        <= rx_q1;
      br_cnt      <= tick ? '0 : br_cnt + 1'b1;
      byte_valid  <= 1'b0;
      batch_valid <= 1'b0;
      frame_error <= 1'b0;
      timeout     <= 1'b0;

      case (state)
        IDLE: begin
          // A start edge always wins over the idle timeout on the same cycle.
          if (!rx_s) begin
            state  <= START;
            s      <= '0;
            to_cnt <= '0;
          end else if (batch_count != '0 && tick) begin
            if (to_cnt == TW'(TIMEOUT_TICKS-1)) begin
              timeout     <= 1'b1;
              batch_count <= '0;
              stage       <= '0;
              to_cnt      <= '0;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end

        START: begin
          if (tick) begin
            if (s == 4'd7) begin
              s <= '0;
              if (!rx_s) begin
                state <= DATA;
                n     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (s == 4'd15) begin
              s     <= '0;
              shreg <= {rx_s, shreg[DBITS-1:1]};
              if (n == NW'(DBITS-1)) state <= STOP;
              else                   n     <= n + 1'b1;
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (s == 4'(SB_TICK-1)) begin
              state <= IDLE;
              s     <= '0;
              if (rx_s) begin
                byte_valid <= 1'b1;
                byte_out   <= shreg;
                to_cnt     <= '0;
                if (batch_count == CW'(BATCH_SIZE-1)) begin
                  batch_valid <= 1'b1;
                  batch_out   <= {stage, shreg};
                  stage       <= '0;
                  batch_count <= '0;
                end else begin
                  stage       <= {stage[SW-DBITS-1:0], shreg};
                  batch_count <= batch_count + 1'b1;
                end
              end else begin
                frame_error <= 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_batch_receiver.sv
// tb/tb_uart_batch_receiver.sv - scoreboard bench for uart_batch_receiver
module tb_uart_batch_receiver;

  localparam int BIT = 64;

  logic        clk_100MHz = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic [31:0] batch_out;
  logic        batch_valid;
  logic [2:0]  batch_count;
  logic        frame_error;
  logic        timeout;
  logic        busy;

  int total = 0, passed = 0;
  int fe_seen = 0, tmo_seen = 0, bv_seen = 0;
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_batches[$];

  always #5 clk_100MHz = ~clk_100MHz;

  uart_batch_receiver #(
    .DBITS(8), .SB_TICK(16), .BR_LIMIT(4), .BR_BITS(10),
    .BATCH_SIZE(4), .TIMEOUT_TICKS(320)
  ) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .rx(rx),
    .byte_out(byte_out), .byte_valid(byte_valid),
    .batch_out(batch_out), .batch_valid(batch_valid),
    .batch_count(batch_count), .frame_error(frame_error),
    .timeout(timeout), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  always @(negedge clk_100MHz) begin
    if (reset) begin
      if (frame_error) fe_seen++;
      if (timeout) tmo_seen++;
      if (byte_valid) begin
        bv_seen++;
        chk("byte_expected", 32'(exp_bytes.size() > 0), 32'd1);
        if (exp_bytes.size() > 0) chk("byte_out", 32'(byte_out), 32'(exp_bytes.pop_front()));
      end
      if (batch_valid) begin
        chk("batch_expected", 32'(exp_batches.size() > 0), 32'd1);
        chk("batch_with_byte", 32'(byte_valid), 32'd1);
        chk("batch_count_at_batch", 32'(batch_count), 32'd0);
        if (exp_batches.size() > 0) chk("batch_out", batch_out, exp_batches.pop_front());
      end
    end
  end

  task automatic line(input logic v, input int cycles);
    rx = v;
    repeat (cycles) @(negedge clk_100MHz);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_val);
    line(1'b0, BIT);
    for (int i = 0; i < 8; i++) line(d[i], BIT);
    if (stop_val) line(1'b1, BIT);
    else begin
      line(1'b0, 40);
      line(1'b1, 2*BIT);
    end
  endtask

  task automatic good(input logic [7:0] d);
    exp_bytes.push_back(d);
    send_byte(d, 1'b1);
  endtask

  task automatic send_batch(input logic [31:0] w);
    exp_batches.push_back(w);
    for (int k = 3; k >= 0; k--) good(w[8*k +: 8]);
  endtask

  initial begin
    int bv0;
    bit hit;

    repeat (4) @(negedge clk_100MHz);
    chk("rst_byte_out", 32'(byte_out), 32'd0);
    chk("rst_batch_out", batch_out, 32'd0);
    chk("rst_pulses", {28'd0, byte_valid, batch_valid, frame_error, timeout}, 32'd0);
    chk("rst_count_busy", {28'd0, batch_count, busy}, 32'd0);
    reset = 1'b1;
    line(1'b1, BIT);

    send_batch(32'h12345678);
    chk("b1_bytes", 32'(bv_seen), 32'd4);
    chk("b1_batch_out", batch_out, 32'h12345678);
    chk("b1_count", 32'(batch_count), 32'd0);

    bv0 = bv_seen;
    line(1'b0, 16);
    chk("glitch_busy", 32'(busy), 32'd1);
    line(1'b1, BIT);
    chk("glitch_idle", 32'(busy), 32'd0);
    chk("glitch_no_pulse", 32'(bv_seen - bv0 + fe_seen), 32'd0);
    chk("glitch_count", 32'(batch_count), 32'd0);

    bv0 = bv_seen;
    send_byte(8'hA5, 1'b0);
    chk("fe_pulse", 32'(fe_seen), 32'd1);
    chk("fe_no_byte", 32'(bv_seen - bv0), 32'd0);
    send_batch(32'h01020304);
    chk("b2_batch_out", batch_out, 32'h01020304);

    good(8'hAA);
    good(8'hBB);
    chk("tmo_count_before", 32'(batch_count), 32'd2);
    repeat (1100) @(negedge clk_100MHz);
    chk("tmo_not_early", 32'(tmo_seen), 32'd0);
    hit = 0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk_100MHz);
      if (tmo_seen != 0) hit = 1;
    end
    chk("tmo_fired", 32'(tmo_seen), 32'd1);
    chk("tmo_count_after", 32'(batch_count), 32'd0);
    chk("tmo_batch_held", batch_out, 32'h01020304);
    send_batch(32'h11223344);
    chk("b3_batch_out", batch_out, 32'h11223344);

    good(8'h55);
    good(8'h66);
    line(1'b0, BIT);
    for (int i = 0; i < 4; i++) line(1'b1, BIT);
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk_100MHz);
    chk("mid_rst_outs", {8'd0, byte_out, 16'd0}, 32'd0);
    chk("mid_rst_batch", batch_out, 32'd0);
    chk("mid_rst_count_busy", {28'd0, batch_count, busy}, 32'd0);
    reset = 1'b1;
    line(1'b1, BIT);
    send_batch(32'hDEADBEEF);
    chk("b4_batch_out", batch_out, 32'hDEADBEEF);

    send_batch(32'hCAFEF00D);
    chk("loop_batch_out", batch_out, 32'hCAFEF00D);

    line(1'b1, BIT);
    chk("sb_bytes_left", 32'(exp_bytes.size()), 32'd0);
    chk("sb_batches_left", 32'(exp_batches.size()), 32'd0);
    chk("fe_total", 32'(fe_seen), 32'd1);
    chk("tmo_total", 32'(tmo_seen), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
